// File: rtl/out_rr_fifo_network.sv
// Per-channel tag FIFOs drained by a round-robin or fixed-priority arbiter
// into one registered output slot tagged with its source channel index.
module out_rr_fifo_network #(
    parameter int NCOUNT   = 8,
    parameter int DWIDTH   = 10,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0,
    parameter int IDW      = $clog2(NCOUNT)
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic [DWIDTH-1:0] dataout    [NCOUNT-1:0],
    input  logic [NCOUNT-1:0] data_valid,
    output logic [NCOUNT-1:0] data_ack,
    output logic [DWIDTH-1:0] tag_data,
    output logic [IDW-1:0]    tag_src,
    output logic              tag_valid,
    input  logic              tag_ready,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DWIDTH-1:0] mem_q    [NCOUNT][DEPTH];
    logic [AW-1:0]     wr_ptr_q [NCOUNT];
    logic [AW-1:0]     rd_ptr_q [NCOUNT];
    logic [LW-1:0]     lvl_q    [NCOUNT];
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    rr_ptr_d;
    logic [DWIDTH-1:0] tag_data_q;
    logic [IDW-1:0]    tag_src_q;
    logic              tag_valid_q;

    logic [NCOUNT-1:0] full;
    logic [NCOUNT-1:0] nonempty;
    logic [NCOUNT-1:0] pop;
    logic              load;
    logic              any_ne;
    logic [IDW-1:0]    grant;

    // FIFO status flags from registered levels only
    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int i = 0; i < NCOUNT; i++) begin
            full[i]     = (lvl_q[i] == LW'(DEPTH));
            nonempty[i] = (lvl_q[i] != '0);
        end
    end

    assign data_ack = data_valid & ~full & {NCOUNT{~aclr}};
    assign load     = ~tag_valid_q | tag_ready;
    assign any_ne   = |nonempty;
    assign busy     = tag_valid_q | any_ne;

    // Arbiter: rotating scan from rr_ptr, or highest non-empty index
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NCOUNT; i++) begin
                if (nonempty[i]) grant = IDW'(i);
            end
        end else begin
            for (int k = 0; k < NCOUNT; k++) begin
                idx = (int'(rr_ptr_q) + k) % NCOUNT;
                if (!found && nonempty[idx]) begin
                    grant = IDW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Pop strobes and the pointer position following the granted channel
    always_comb begin
        pop = '0;
        for (int i = 0; i < NCOUNT; i++) begin
            pop[i] = load & any_ne & (grant == IDW'(i));
        end
        rr_ptr_d = (grant == IDW'(NCOUNT - 1)) ? '0 : grant + IDW'(1);
    end

    // FIFO storage, written only on an accepted ingress word
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCOUNT; i++) begin
            if (data_ack[i]) mem_q[i][wr_ptr_q[i]] <= dataout[i];
        end
    end

    // FIFO pointers and levels: level moves by +push -pop
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < NCOUNT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                lvl_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCOUNT; i++) begin
                if (data_ack[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                if (pop[i])      rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                lvl_q[i] <= lvl_q[i] + LW'(data_ack[i]) - LW'(pop[i]);
            end
        end
    end

    // Output slot: reload when empty or drained, hold under backpressure
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            tag_data_q  <= '0;
            tag_src_q   <= '0;
            tag_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (load) begin
            tag_valid_q <= any_ne;
            if (any_ne) begin
                tag_data_q <= mem_q[grant][rd_ptr_q[grant]];
                tag_src_q  <= grant;
                rr_ptr_q   <= rr_ptr_d;
            end
        end
    end

    assign tag_data  = tag_data_q;
    assign tag_src   = tag_src_q;
    assign tag_valid = tag_valid_q;

endmodule

// File: tb/tb_out_rr_fifo_network.sv
// Directed and soak bench for out_rr_fifo_network; a round-robin and a
// fixed-priority instance share the same ingress stimulus.
module tb_out_rr_fifo_network;
    localparam int NC    = 8;
    localparam int DW    = 10;
    localparam int NSOAK = 10000;

    logic          clock = 1'b0;
    logic          aclr  = 1'b0;
    logic [DW-1:0] dout [NC-1:0];
    logic [NC-1:0] dval;
    logic          trdy;

    logic [NC-1:0] ack_rr, ack_fp;
    logic [DW-1:0] td_rr, td_fp;
    logic [2:0]    ts_rr, ts_fp;
    logic          tv_rr, tv_fp, busy_rr, busy_fp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    out_rr_fifo_network #(.NCOUNT(NC), .DWIDTH(DW), .DEPTH(4), .ARB_MODE(0)) u_rr (
        .clock(clock), .aclr(aclr), .dataout(dout), .data_valid(dval),
        .data_ack(ack_rr), .tag_data(td_rr), .tag_src(ts_rr),
        .tag_valid(tv_rr), .tag_ready(trdy), .busy(busy_rr)
    );

    out_rr_fifo_network #(.NCOUNT(NC), .DWIDTH(DW), .DEPTH(4), .ARB_MODE(1)) u_fp (
        .clock(clock), .aclr(aclr), .dataout(dout), .data_valid(dval),
        .data_ack(ack_fp), .tag_data(td_fp), .tag_src(ts_fp),
        .tag_valid(tv_fp), .tag_ready(trdy), .busy(busy_fp)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_in();
        dval = '0;
        for (int i = 0; i < NC; i++) dout[i] = '0;
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        step();
        aclr = 1'b0;
    endtask

    // soak state
    logic [DW-1:0] sb [NC][$];
    int            sq    [NC];
    int            pend  [NC];
    int            waitc [NC];
    int            maxwait;
    logic          prev_load;
    logic [NC-1:0] last_ack;
    logic [DW-1:0] expw;
    int            acks;
    int            src;

    initial begin
        idle_in();
        trdy = 1'b0;

        // reset values
        @(negedge clock);
        aclr    = 1'b1;
        dval[0] = 1'b1;
        #1;
        chk("rst_valid", tv_rr, 0);
        chk("rst_busy", busy_rr, 0);
        chk("rst_data", td_rr, 0);
        chk("rst_src", ts_rr, 0);
        chk("rst_ack", ack_rr, 0);
        step();
        aclr = 1'b0;
        dval = '0;

        // T2 latency
        dval[5] = 1'b1;
        dout[5] = 10'h2A1;
        trdy    = 1'b1;
        #1;
        chk("t2_ack", ack_rr[5], 1);
        chk("t2_pre_valid", tv_rr, 0);
        step();
        dval = '0;
        #1;
        chk("t2_mid_valid", tv_rr, 0);
        step();
        chk("t2_valid", tv_rr, 1);
        chk("t2_data", td_rr, 10'h2A1);
        chk("t2_src", ts_rr, 5);
        step();
        chk("t2_once", tv_rr, 0);

        // T3 round-robin from a fresh pointer
        do_reset();
        dval = 8'b1000_1001;
        for (int c = 0; c < NC; c++) dout[c] = DW'(c * 16);
        step();
        for (int c = 0; c < NC; c++) dout[c] = DW'(c * 16 + 1);
        step();
        dval = '0;
        trdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            int ec;
            ec = (n % 3 == 0) ? 0 : (n % 3 == 1) ? 3 : 7;
            chk("t3_valid", tv_rr, 1);
            chk("t3_src", ts_rr, ec);
            chk("t3_data", td_rr, ec * 16 + n / 3);
            step();
        end
        chk("t3_end_valid", tv_rr, 0);
        chk("t3_end_busy", busy_rr, 0);

        // T4 backpressure and full
        trdy    = 1'b0;
        dval[2] = 1'b1;
        acks    = 0;
        for (int n = 0; n < 10; n++) begin
            dout[2] = DW'(10'h200 + acks);
            #1;
            if (ack_rr[2]) acks++;
            step();
        end
        #1;
        chk("t4_acks", acks, 5);
        chk("t4_full_ack", ack_rr[2], 0);
        chk("t4_hold_valid", tv_rr, 1);
        chk("t4_hold_data", td_rr, 10'h200);
        dval = '0;
        trdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("t4_data", td_rr, 10'h200 + n);
            chk("t4_src", ts_rr, 2);
            step();
        end
        chk("t4_end_valid", tv_rr, 0);

        // T5 fixed priority
        trdy = 1'b0;
        dval = 8'b0100_0010;
        for (int n = 0; n < 3; n++) begin
            dout[1] = DW'(10'h100 + n);
            dout[6] = DW'(10'h160 + n);
            step();
        end
        dval = '0;
        trdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            chk("t5_src", ts_fp, (n < 3) ? 6 : 1);
            chk("t5_data", td_fp, (n < 3) ? 10'h160 + n : 10'h100 + n - 3);
            step();
        end
        chk("t5_end_valid", tv_fp, 0);

        // T1 reset mid-traffic
        trdy = 1'b0;
        dval = 8'b0101_0010;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < NC; c++) dout[c] = DW'(c * 16 + 8 + n);
            step();
        end
        chk("t1_pre_busy", busy_rr, 1);
        aclr    = 1'b1;
        dval[0] = 1'b1;
        #1;
        chk("t1_rst_valid", tv_rr, 0);
        chk("t1_rst_busy", busy_rr, 0);
        chk("t1_rst_ack", ack_rr, 0);
        step();
        aclr = 1'b0;
        dval = '0;
        trdy = 1'b1;
        step();
        step();
        chk("t1_post_valid", tv_rr, 0);
        chk("t1_post_busy", busy_rr, 0);
        dval[3] = 1'b1;
        dout[3] = 10'h155;
        step();
        dval = '0;
        step();
        chk("t1_new_valid", tv_rr, 1);
        chk("t1_new_data", td_rr, 10'h155);
        chk("t1_new_src", ts_rr, 3);
        step();

        // T6 random soak with scoreboard and fairness tracking
        do_reset();
        for (int c = 0; c < NC; c++) begin
            sq[c]    = 0;
            pend[c]  = 0;
            waitc[c] = 0;
        end
        maxwait   = 0;
        prev_load = 1'b0;
        last_ack  = '0;
        for (int cyc = 0; cyc < NSOAK + 40; cyc++) begin
            if (prev_load && tv_rr) begin
                src = int'(ts_rr);
                for (int c = 0; c < NC; c++) begin
                    if (pend[c] > 0 && c != src) begin
                        waitc[c]++;
                        if (waitc[c] > maxwait) maxwait = waitc[c];
                    end else begin
                        waitc[c] = 0;
                    end
                end
                chk("t6_pop_pending", pend[src] > 0, 1);
                if (pend[src] > 0) pend[src]--;
            end
            for (int c = 0; c < NC; c++) pend[c] += int'(last_ack[c]);
            for (int c = 0; c < NC; c++) begin
                dout[c] = DW'((c << 7) | (sq[c] & 127));
                dval[c] = (cyc < NSOAK) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            trdy = (cyc < NSOAK) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            last_ack = ack_rr;
            for (int c = 0; c < NC; c++) begin
                if (last_ack[c]) begin
                    sb[c].push_back(dout[c]);
                    sq[c]++;
                end
            end
            if (tv_rr && trdy) begin
                src = int'(ts_rr);
                chk("t6_nonempty", sb[src].size() != 0, 1);
                if (sb[src].size() != 0) begin
                    expw = sb[src].pop_front();
                    chk("t6_data", td_rr, expw);
                end
            end
            prev_load = ~tv_rr | trdy;
            step();
        end
        for (int c = 0; c < NC; c++) chk("t6_drained", sb[c].size(), 0);
        chk("t6_busy", busy_rr, 0);
        chk("t6_fair", maxwait <= NC, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
